plic_lite: RTL and testbench

PLIC_LITE -- requirements
Module: plic_lite

---
 rtl/plic_lite_pkg.sv | 17 +
 rtl/plic_lite_if.sv | 28 ++
 rtl/plic_lite_gateway.sv | 66 ++++++
 rtl/plic_lite.sv | 98 +++++++++
 tb/tb_plic_lite.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/plic_lite_pkg.sv
// Shared definitions for plic_lite: gateway state, config target select
// encodings and the "no interrupt" ID.
package plic_lite_pkg;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_CLAIMED = 2'd2
  } gw_state_e;

  localparam logic [1:0] CFG_PRIO = 2'd0;
  localparam logic [1:0] CFG_EN   = 2'd1;
  localparam logic [1:0] CFG_THR  = 2'd2;

  localparam int unsigned ID_NONE = 0;

endpackage

// File: rtl/plic_lite_if.sv
// Config write, claim and completion signals of plic_lite; the hart-side
// agent is the master, the controller is the slave.
interface plic_lite_if #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
);
  localparam int ID_W = $clog2(NUM_SRC + 1);

  logic              cfg_we;
  logic [1:0]        cfg_sel;
  logic [ID_W-1:0]   cfg_id;
  logic [PRIO_W-1:0] cfg_data;
  logic              claim_req;
  logic              claim_valid;
  logic [ID_W-1:0]   claim_id;
  logic              complete_valid;
  logic [ID_W-1:0]   complete_id;

  modport master (
    output cfg_we, cfg_sel, cfg_id, cfg_data, claim_req, complete_valid, complete_id,
    input  claim_valid, claim_id
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_id, cfg_data, claim_req, complete_valid, complete_id,
    output claim_valid, claim_id
  );
endinterface

// File: rtl/plic_lite_gateway.sv
// Per-source interrupt gateway (IDLE/PENDING/CLAIMED). Edge detection and
// re-arm are built only when PLIC_EDGE_EN is defined; otherwise level-only.
module plic_gateway
  import plic_lite_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_src,
  input  logic i_edge,
  input  logic i_claim,
  input  logic i_complete,
  output logic o_pending
);

  gw_state_e r_state;
  logic      w_trig;
  logic      w_reopen;

`ifdef PLIC_EDGE_EN
  logic r_src_d;
  logic r_rearm;
  logic w_rise;

  assign w_rise   = i_src & ~r_src_d;
  assign w_trig   = i_edge ? w_rise : i_src;
  // an edge arriving in the completion cycle itself also re-arms
  assign w_reopen = i_edge & (r_rearm | w_rise);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_d <= 1'b0;
      r_rearm <= 1'b0;
    end else begin
      r_src_d <= i_src;
      if (r_state == GW_CLAIMED) begin
        if (i_complete)
          r_rearm <= 1'b0;
        else if (i_edge && w_rise)
          r_rearm <= 1'b1;
      end
    end
  end
`else
  logic w_unused_edge;

  assign w_unused_edge = i_edge;
  assign w_trig        = i_src;
  assign w_reopen      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= GW_IDLE;
    end else begin
      case (r_state)
        GW_IDLE:    if (w_trig) r_state <= GW_PENDING;
        GW_PENDING: if (i_claim) r_state <= GW_CLAIMED;
        GW_CLAIMED: if (i_complete) r_state <= w_reopen ? GW_PENDING : GW_IDLE;
        default:    r_state <= GW_IDLE;
      endcase
    end
  end

  assign o_pending = (r_state == GW_PENDING);

endmodule

// File: rtl/plic_lite.sv
// Lightweight platform interrupt controller: per-source gateways, priority
// arbitration, claim/complete. Optional edge mode via PLIC_EDGE_EN.
module plic_lite
  import plic_lite_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic [NUM_SRC-1:0] src_edge,
  plic_lite_if.slave         bus,
  output logic               ext_irq
);

  localparam int ID_W = $clog2(NUM_SRC + 1);

  logic [PRIO_W-1:0] r_prio [NUM_SRC];
  logic [NUM_SRC-1:0] r_en;
  logic [PRIO_W-1:0] r_thr;

  logic [NUM_SRC-1:0] w_pending;
  logic [NUM_SRC-1:0] w_claim_hit;
  logic [NUM_SRC-1:0] w_cmpl_hit;
  logic [ID_W-1:0]    w_best_id;
  logic [PRIO_W-1:0]  w_best_prio;

  logic [ID_W-1:0]    r_best_id_p1;
  logic               r_ext_irq_p1;
  logic               r_claim_vld_p1;
  logic [ID_W-1:0]    r_claim_id_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) r_prio[i] <= '0;
      r_en  <= '0;
      r_thr <= '0;
    end else if (bus.cfg_we) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (bus.cfg_id == ID_W'(i + 1)) begin
          if (bus.cfg_sel == CFG_PRIO) r_prio[i] <= bus.cfg_data;
          if (bus.cfg_sel == CFG_EN)   r_en[i]   <= bus.cfg_data[0];
        end
      end
      if (bus.cfg_sel == CFG_THR) r_thr <= bus.cfg_data;
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
    assign w_claim_hit[g] = bus.claim_req && (r_best_id_p1 == ID_W'(g + 1));
    assign w_cmpl_hit[g]  = bus.complete_valid && (bus.complete_id == ID_W'(g + 1));

    plic_gateway u_gw (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_src      (src_irq[g]),
      .i_edge     (src_edge[g]),
      .i_claim    (w_claim_hit[g]),
      .i_complete (w_cmpl_hit[g]),
      .o_pending  (w_pending[g])
    );
  end

  // p0: arbitration; the source handed out this cycle is already excluded so
  // a back-to-back claim sees the next winner
  always_comb begin
    w_best_id   = ID_W'(ID_NONE);
    w_best_prio = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_pending[i] && !w_claim_hit[i] && r_en[i] &&
          (r_prio[i] > r_thr) && (r_prio[i] > w_best_prio)) begin
        w_best_id   = ID_W'(i + 1);
        w_best_prio = r_prio[i];
      end
    end
  end

  // p1: registered winner, interrupt line and claim response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_best_id_p1   <= ID_W'(ID_NONE);
      r_ext_irq_p1   <= 1'b0;
      r_claim_vld_p1 <= 1'b0;
      r_claim_id_p1  <= ID_W'(ID_NONE);
    end else begin
      r_best_id_p1   <= w_best_id;
      r_ext_irq_p1   <= (w_best_id != ID_W'(ID_NONE));
      r_claim_vld_p1 <= bus.claim_req;
      r_claim_id_p1  <= bus.claim_req ? r_best_id_p1 : ID_W'(ID_NONE);
    end
  end

  assign bus.claim_valid = r_claim_vld_p1;
  assign bus.claim_id    = r_claim_id_p1;
  assign ext_irq         = r_ext_irq_p1;

endmodule

// File: tb/tb_plic_lite.sv
// Self-checking bench for plic_lite: directed scenarios plus random traffic
// against a per-source behavioural model (honours PLIC_EDGE_EN).
module tb_plic_lite;

  localparam int N    = 8;
  localparam int ID_W = $clog2(N + 1);

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] src_irq;
  logic [N-1:0] src_edge;
  logic         ext_irq;

  plic_lite_if #(.NUM_SRC(N), .PRIO_W(3)) bus ();

  plic_lite #(.NUM_SRC(N), .PRIO_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .src_irq  (src_irq),
    .src_edge (src_edge),
    .bus      (bus),
    .ext_irq  (ext_irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // model: pending/claimed/re-arm per ID, last sampled src, config, outputs
  bit m_pend [N+1];
  bit m_clm  [N+1];
  bit m_rearm[N+1];
  bit m_prev [N+1];
  int m_prio [N+1];
  bit m_en   [N+1];
  int m_thr, m_best, m_cid;
  bit m_ext, m_cv;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit edge_mode(input int id);
`ifdef PLIC_EDGE_EN
    return src_edge[id-1];
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= N; i++) begin
      m_pend[i] = 0; m_clm[i] = 0; m_rearm[i] = 0; m_prev[i] = 0;
      m_prio[i] = 0; m_en[i] = 0;
    end
    m_thr = 0; m_best = 0; m_cid = 0; m_ext = 0; m_cv = 0;
  endtask

  task automatic model_edge();
    bit avail[N+1];
    bit np[N+1], nc[N+1], nr[N+1];
    int nbest, bprio, cid, did;
    bit s, rise, e;
    cid = int'(bus.cfg_id);
    did = int'(bus.complete_id);
    // winner for the next cycle: what is pending now, minus what is handed out now
    for (int i = 0; i <= N; i++) avail[i] = m_pend[i];
    if (bus.claim_req && m_best != 0) avail[m_best] = 0;
    nbest = 0; bprio = 0;
    for (int i = 1; i <= N; i++)
      if (avail[i] && m_en[i] && m_prio[i] > m_thr && m_prio[i] > bprio) begin
        nbest = i; bprio = m_prio[i];
      end
    for (int i = 1; i <= N; i++) begin
      s = src_irq[i-1]; rise = s && !m_prev[i]; e = edge_mode(i);
      np[i] = m_pend[i]; nc[i] = m_clm[i]; nr[i] = m_rearm[i];
      if (!m_pend[i] && !m_clm[i]) begin
        if (e ? rise : s) np[i] = 1;
      end else if (m_pend[i]) begin
        if (bus.claim_req && m_best == i) begin np[i] = 0; nc[i] = 1; end
      end else begin
        if (bus.complete_valid && did == i) begin
          nc[i] = 0; nr[i] = 0;
          if (e && (m_rearm[i] || rise)) np[i] = 1;
        end else if (e && rise) nr[i] = 1;
      end
      m_prev[i] = s;
    end
    for (int i = 1; i <= N; i++) begin m_pend[i] = np[i]; m_clm[i] = nc[i]; m_rearm[i] = nr[i]; end
    m_cv  = bus.claim_req;
    m_cid = bus.claim_req ? m_best : 0;
    m_best = nbest;
    m_ext  = (nbest != 0);
    if (bus.cfg_we) begin
      if (bus.cfg_sel == 2'd0 && cid >= 1 && cid <= N) m_prio[cid] = int'(bus.cfg_data);
      if (bus.cfg_sel == 2'd1 && cid >= 1 && cid <= N) m_en[cid] = bus.cfg_data[0];
      if (bus.cfg_sel == 2'd2) m_thr = int'(bus.cfg_data);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("ext_irq", int'(ext_irq), int'(m_ext));
    chk("claim_valid", int'(bus.claim_valid), int'(m_cv));
    if (m_cv) chk("claim_id", int'(bus.claim_id), m_cid);
  endtask

  task automatic idle_inputs();
    bus.cfg_we = 0; bus.cfg_sel = '0; bus.cfg_id = '0; bus.cfg_data = '0;
    bus.claim_req = 0; bus.complete_valid = 0; bus.complete_id = '0;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    idle_inputs();
    src_irq = '0; src_edge = '0;
    model_reset();
    #1;
    chk("rst_ext_irq", int'(ext_irq), 0);
    chk("rst_claim_valid", int'(bus.claim_valid), 0);
    chk("rst_claim_id", int'(bus.claim_id), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic do_cfg(input int sel, input int id, input int data);
    bus.cfg_we = 1; bus.cfg_sel = 2'(sel); bus.cfg_id = ID_W'(id); bus.cfg_data = 3'(data);
    step();
    bus.cfg_we = 0;
  endtask

  task automatic do_claim(input string tag, input int exp_id);
    bus.claim_req = 1;
    step();
    bus.claim_req = 0;
    chk({tag, "_valid"}, int'(bus.claim_valid), 1);
    chk(tag, int'(bus.claim_id), exp_id);
  endtask

  task automatic do_complete(input int id);
    bus.complete_valid = 1; bus.complete_id = ID_W'(id);
    step();
    bus.complete_valid = 0; bus.complete_id = '0;
  endtask

  initial begin
    bit exp_edge;
    int q[$];
    int pick;
`ifdef PLIC_EDGE_EN
    exp_edge = 1;
`else
    exp_edge = 0;
`endif
    apply_reset();

    // level source: latency, claim, re-pend after completion
    do_cfg(0, 3, 2); do_cfg(1, 3, 1);
    src_irq[2] = 1;
    step(); chk("lvl_ext_1cyc", int'(ext_irq), 0);
    step(); chk("lvl_ext_2cyc", int'(ext_irq), 1);
    do_claim("lvl_claim", 3);
    chk("lvl_ext_after_claim", int'(ext_irq), 0);
    do_complete(3); step(); step();
    chk("lvl_ext_repend", int'(ext_irq), 1);
    do_claim("lvl_reclaim", 3);
    src_irq[2] = 0; do_complete(3); step(); step();
    chk("lvl_ext_quiet", int'(ext_irq), 0);

    // priority and tie-break
    apply_reset();
    do_cfg(0, 2, 5); do_cfg(0, 5, 5); do_cfg(0, 7, 6);
    do_cfg(1, 2, 1); do_cfg(1, 5, 1); do_cfg(1, 7, 1);
    src_irq = 8'b0101_0010;
    step(); step();
    do_claim("prio_first", 7);
    do_claim("prio_second", 2);
    do_claim("prio_third", 5);
    do_claim("prio_none", 0);

    // threshold
    apply_reset();
    do_cfg(0, 4, 3); do_cfg(1, 4, 1); do_cfg(2, 1, 3);
    src_irq[3] = 1;
    step(); step(); step();
    chk("thr_blocked", int'(ext_irq), 0);
    do_cfg(2, 1, 2);
    chk("thr_write_cycle", int'(ext_irq), 0);
    step(); chk("thr_open", int'(ext_irq), 1);
    do_claim("thr_claim", 4);

    // edge source with re-arm
    apply_reset();
    src_edge[0] = 1;
    do_cfg(0, 1, 1); do_cfg(1, 1, 1);
    src_irq[0] = 1; step(); src_irq[0] = 0; step();
    chk("edge_ext", int'(ext_irq), 1);
    do_claim("edge_claim", 1);
    src_irq[0] = 1; step(); src_irq[0] = 0; step();
    do_complete(1); step(); step();
    chk("edge_rearm_ext", int'(ext_irq), int'(exp_edge));
    do_claim("edge_reclaim", exp_edge ? 1 : 0);

    // bad completes and empty claim
    apply_reset();
    do_cfg(0, 6, 2); do_cfg(1, 6, 1);
    src_irq[5] = 1; step(); step();
    do_complete(6); step();
    chk("bad_unclaimed_ext", int'(ext_irq), 1);
    do_claim("bad_claim6", 6);
    do_complete(0); do_complete(9); step();
    do_claim("bad_still_claimed", 0);
    do_complete(6); step(); step();
    do_claim("bad_reclaim6", 6);
    src_irq[5] = 0; do_complete(6); step(); step();
    do_claim("bad_empty_claim", 0);

    // reset right after a claim request
    apply_reset();
    do_cfg(0, 3, 2); do_cfg(1, 3, 1);
    src_irq[2] = 1; step(); step();
    bus.claim_req = 1; step(); bus.claim_req = 0;
    rst_n = 0; model_reset(); #1;
    chk("midrst_claim_valid", int'(bus.claim_valid), 0);
    chk("midrst_ext", int'(ext_irq), 0);
    @(posedge clk); #1; rst_n = 1;
    src_irq = '1;
    for (int i = 1; i <= N; i++) do_cfg(1, i, 1);
    step(); step(); step();
    chk("midrst_prio_zero_ext", int'(ext_irq), 0);
    chk("midrst_no_claim_valid", int'(bus.claim_valid), 0);

    // random traffic
    apply_reset();
    src_edge = N'($urandom);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) src_irq = src_irq ^ (N'(1) << $urandom_range(0, N-1));
      bus.cfg_we   = ($urandom_range(0, 5) == 0);
      bus.cfg_sel  = 2'($urandom_range(0, 3));
      bus.cfg_id   = ID_W'($urandom_range(0, 10));
      bus.cfg_data = 3'($urandom);
      bus.claim_req = ($urandom_range(0, 3) == 0);
      bus.complete_valid = ($urandom_range(0, 2) == 0);
      q.delete();
      for (int i = 1; i <= N; i++) if (m_clm[i]) q.push_back(i);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) pick = q[$urandom_range(0, q.size() - 1)];
      else pick = $urandom_range(0, 12);
      bus.complete_id = ID_W'(pick);
      step();
    end
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
